regfile_write_arbiter: RTL



---
 rtl/regfile_write_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single write port of an 8-entry register file between four
// requesters. Each cycle at most one request is granted (one-hot, combinational).
// The winning address and data are registered, and the eight one-hot row
// enables are decoded from the registered address.
// Optional feature macro: RR_ARB_EN. When it is defined, arbitration is
// round-robin using a 2-bit priority pointer. When it is undefined (the default),
// arbitration is fixed priority with requester 0 highest and no pointer is built.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          req,
  input  logic [11:0]         req_addr,
  input  logic [4*DATA_W-1:0] req_data,
  output logic [3:0]          grant,
  input  logic                wr_stall,
  output logic                wr_en,
  output logic [2:0]          wr_addr,
  output logic [7:0]          wr_sel,
  output logic [DATA_W-1:0]   wr_data
);

  localparam int unsigned N_REQ = 4;

  logic [2:0]        addr_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];
  logic [1:0]        win;
  logic              any_req;
  logic              accept;

  // Split the packed request buses into per-requester entries
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      addr_arr[i] = req_addr[3*i +: 3];
      data_arr[i] = req_data[DATA_W*i +: DATA_W];
    end
  end

`ifdef RR_ARB_EN
  logic [1:0] ptr;
  logic [1:0] idx;

  // Round-robin search starting at ptr, wrapping mod 4; first asserted req wins
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ptr + 2'(k);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
  end

  // Priority pointer advances past the winner only on an accepted grant
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= win + 2'd1;
    end
  end
`else
  // Fixed priority: lowest-numbered asserted request wins
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!any_req && req[k]) begin
        any_req = 1'b1;
        win     = 2'(k);
      end
    end
  end
`endif

  // Grant is suppressed during reset and stall; it never depends on addr/data
  always_comb begin
    accept = any_req && !reset && !wr_stall;
    grant  = '0;
    if (accept) begin
      grant[win] = 1'b1;
    end
  end

  // Output register: a stall freezes everything so a pending write stays presented
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (!wr_stall) begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= addr_arr[win];
        wr_data <= data_arr[win];
      end
    end
  end

  // Row enable decode from the registered write valid and address
  always_comb begin
    wr_sel = '0;
    if (wr_en) begin
      wr_sel[wr_addr] = 1'b1;
    end
  end

  // Structural invariants of the outputs
  a_grant_onehot0 : assert property (@(posedge clk) $onehot0(grant));
  a_sel_onehot0   : assert property (@(posedge clk) $onehot0(wr_sel));
  a_no_grant_stall: assert property (@(posedge clk) (wr_stall || reset) |-> (grant == 4'b0000));

endmodule
